mul_tail_pipe: RTL

- Multiply pipeline stages M2..M5, directly downstream of the M1 operand stage.
- Consumes the two 32-bit operands M1 forwards, with a valid bit and destination register tag.
- Computes the low 32 bits of the unsigned/two's-complement product over STAGES clocked stages.
- Presents the result, tag and valid to writeback, and gives the hazard unit a pending-destination lookup.

---
 rtl/mul_tail_pipe_pkg.sv | 14 +
 rtl/mul_stage_reg.sv | 36 +++
 rtl/mul_tail_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/mul_tail_pipe_pkg.sv
// Shared constants and slot type for the multiply tail pipeline (M2..M5).
package mul_tail_pipe_pkg;

    localparam int MUL_STAGES_DEFAULT   = 4;
    localparam int TAG_SIZE_DEFAULT     = 5;
    localparam int OPERAND_SIZE_DEFAULT = 32;

    typedef struct packed {
        logic                            valid;
        logic [TAG_SIZE_DEFAULT-1:0]     tag;
        logic [OPERAND_SIZE_DEFAULT-1:0] data;
    } slot_t;

endpackage

// File: rtl/mul_stage_reg.sv
// One pipeline slot register: load, hold on stall, clear valid on flush, full clear on reset.
module mul_stage_reg
    import mul_tail_pipe_pkg::*;
#(
    parameter type slot_t = mul_tail_pipe_pkg::slot_t
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  hold,
    input  logic  clear,
    input  slot_t slot_in,
    output slot_t slot_out
);

    slot_t slot_d;
    slot_t slot_q;

    // Flush only kills the valid bit; data/tag may keep whatever they would have had.
    always_comb begin
        slot_d = hold ? slot_q : slot_in;
        if (clear) begin
            slot_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_out = slot_q;

endmodule

// File: rtl/mul_tail_pipe.sv
// Multiply stages M2..M(STAGES+1): partial products in M2, combine in M3, then pure delay.
module mul_tail_pipe
    import mul_tail_pipe_pkg::*;
#(
    parameter int OPERAND_SIZE = OPERAND_SIZE_DEFAULT,
    parameter int TAG_SIZE     = TAG_SIZE_DEFAULT,
    parameter int STAGES       = MUL_STAGES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPERAND_SIZE-1:0] mt_operand1,
    input  logic [OPERAND_SIZE-1:0] mt_operand2,
    input  logic                    mt_valid_in,
    input  logic [TAG_SIZE-1:0]     mt_tag_in,
    input  logic                    mt_stall_in,
    input  logic                    mt_flush,
    output logic                    mt_stall,
    output logic [OPERAND_SIZE-1:0] mt_result,
    output logic [TAG_SIZE-1:0]     mt_tag_out,
    output logic                    mt_valid_out,
    input  logic [TAG_SIZE-1:0]     mt_query_tag,
    output logic                    mt_query_hit
);

    localparam int H = OPERAND_SIZE / 2;

    typedef struct packed {
        logic                    valid;
        logic [TAG_SIZE-1:0]     tag;
        logic [OPERAND_SIZE-1:0] data;
    } stage_slot_t;

    typedef struct packed {
        logic                    valid;
        logic [TAG_SIZE-1:0]     tag;
        logic [OPERAND_SIZE-1:0] p_ll;
        logic [H-1:0]            p_lh;
        logic [H-1:0]            p_hl;
    } m2_slot_t;

    logic [H-1:0] a_l, a_h, b_l, b_h;
    logic [H-1:0] cross_sum;
    logic         any_valid;
    logic         hit;

    m2_slot_t     m2_in;
    m2_slot_t     m2_out;
    stage_slot_t  st_in  [1:STAGES-1];
    stage_slot_t  st_out [1:STAGES-1];

    always_comb begin
        a_l = mt_operand1[H-1:0];
        a_h = mt_operand1[OPERAND_SIZE-1:H];
        b_l = mt_operand2[H-1:0];
        b_h = mt_operand2[OPERAND_SIZE-1:H];

        m2_in.valid = mt_valid_in & ~mt_flush;
        m2_in.tag   = mt_tag_in;
        m2_in.p_ll  = {{H{1'b0}}, a_l} * {{H{1'b0}}, b_l};
        // aH*bH only contributes above bit OPERAND_SIZE-1, so it is never formed.
        m2_in.p_lh  = a_l * b_h;
        m2_in.p_hl  = a_h * b_l;

        cross_sum      = m2_out.p_lh + m2_out.p_hl;
        st_in[1].valid = m2_out.valid;
        st_in[1].tag   = m2_out.tag;
        st_in[1].data  = m2_out.p_ll + {cross_sum, {H{1'b0}}};
        for (int k = 2; k < STAGES; k++) begin
            st_in[k] = st_out[k-1];
        end

        any_valid = m2_out.valid;
        hit       = m2_out.valid && (m2_out.tag == mt_query_tag);
        for (int k = 1; k < STAGES; k++) begin
            any_valid = any_valid | st_out[k].valid;
            hit       = hit | (st_out[k].valid && (st_out[k].tag == mt_query_tag));
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_m2
            mul_stage_reg #(.slot_t(m2_slot_t)) u_reg (
                .clk      (clk),
                .reset    (reset),
                .hold     (mt_stall_in),
                .clear    (mt_flush),
                .slot_in  (m2_in),
                .slot_out (m2_out)
            );
        end else begin : g_tail
            mul_stage_reg #(.slot_t(stage_slot_t)) u_reg (
                .clk      (clk),
                .reset    (reset),
                .hold     (mt_stall_in),
                .clear    (mt_flush),
                .slot_in  (st_in[g]),
                .slot_out (st_out[g])
            );
        end
    end

    assign mt_valid_out = st_out[STAGES-1].valid;
    assign mt_result    = st_out[STAGES-1].data;
    assign mt_tag_out   = st_out[STAGES-1].tag;
    assign mt_query_hit = hit;
    assign mt_stall     = mt_stall_in & (mt_valid_in | any_valid);

endmodule
